bsg_cgol_ctrl: RTL

Sequencing controller for a board_width_p x board_width_p array of Game-of-Life cells. It accepts an initial board and a generation count through a ready/valid handshake, loads the board into the array, and enables the array for exactly that many generations. It then holds the final board on a valid/yumi output. It sits between the host-facing I/O logic and the cell array, and drives the array's broadcast en_i, per-cell update_i and update_val_i inputs.

---
 rtl/bsg_cgol_ctrl_if.sv | 37 +++
 rtl/bsg_cgol_ctrl.sv | 83 ++++++++
 2 files changed

// File: rtl/bsg_cgol_ctrl_if.sv
// Host-side and cell-array-side signal bundle for the Game-of-Life controller.
interface bsg_cgol_ctrl_if #(
    parameter int unsigned board_width_p     = 32,
    parameter int unsigned max_game_length_p = 1000
);
    localparam int unsigned N = board_width_p * board_width_p;
    localparam int unsigned L = $clog2(max_game_length_p + 1);

    // host input side
    logic         v_i;
    logic [N-1:0] data_i;
    logic [L-1:0] frames_i;
    logic         ready_o;

    // cell array side
    logic         en_o;
    logic         update_o;
    logic [N-1:0] update_val_o;
    logic [N-1:0] cells_i;

    // host output side
    logic         v_o;
    logic [N-1:0] data_o;
    logic         yumi_i;

    // environment: drives the game request, consumes the result, models the cells
    modport master (
        output v_i, data_i, frames_i, yumi_i, cells_i,
        input  ready_o, en_o, update_o, update_val_o, v_o, data_o
    );

    // controller
    modport slave (
        input  v_i, data_i, frames_i, yumi_i, cells_i,
        output ready_o, en_o, update_o, update_val_o, v_o, data_o
    );
endinterface

// File: rtl/bsg_cgol_ctrl.sv
// Sequences one Game-of-Life run: accept board + frame count, load the array,
// enable it for exactly that many generations, then present the final board.
module bsg_cgol_ctrl #(
    parameter int unsigned board_width_p     = 32,
    parameter int unsigned max_game_length_p = 1000
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    bsg_cgol_ctrl_if.slave io
);
    localparam int unsigned N = board_width_p * board_width_p;
    localparam int unsigned L = $clog2(max_game_length_p + 1);
    localparam logic [L-1:0] MaxFrames = L'(max_game_length_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [L-1:0] count_q, count_d;
    logic [N-1:0] update_val_q, update_val_d;

    // Next-state, frame counter and load-board register update.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        update_val_d = update_val_q;
        case (state_q)
            IDLE: begin
                // ready_o is 1 whenever this branch can take effect
                if (io.v_i) begin
                    state_d      = LOAD;
                    update_val_d = io.data_i;
                    count_d      = (io.frames_i > MaxFrames) ? MaxFrames : io.frames_i;
                end
            end
            LOAD: begin
                state_d = (count_q != '0) ? BUSY : DONE;
            end
            BUSY: begin
                // only entered with count_q >= 1, so this never wraps
                count_d = count_q - L'(1);
                if (count_q == L'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            update_val_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            update_val_q <= update_val_d;
        end
    end

    // Outputs decoded from state; control strobes are killed immediately by reset.
    assign io.ready_o      = reset_n_i && (state_q == IDLE);
    assign io.update_o     = reset_n_i && (state_q == LOAD);
    assign io.en_o         = reset_n_i && (state_q == BUSY);
    assign io.v_o          = reset_n_i && (state_q == DONE);
    assign io.update_val_o = update_val_q;
    // array is frozen in DONE, so the pass-through is stable
    assign io.data_o       = io.cells_i;

endmodule
